// File: rtl/ballot_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ballot_input_ctrl
// Purpose  : Debounces candidate buttons and enforces one vote per armed ballot.
// Revision : 1.0
// ============================================================================
module ballot_input_ctrl #(
  parameter int NUM_CAND        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                voter_en,
  input  logic [NUM_CAND-1:0] btn,
  output logic [NUM_CAND-1:0] vote_inc,
  output logic                ready,
  output logic                voted,
  output logic                timeout,
  output logic [9:0]          ballots_cast
);

  localparam int c_DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]        c_BC_MAX  = 10'd999;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_CAST     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CAND-1:0] r_sync1;
  logic [NUM_CAND-1:0] r_sync2;
  logic [NUM_CAND-1:0] w_deb;
  logic [NUM_CAND-1:0] w_press;
  logic                r_ven_q;
  logic [c_TO_W-1:0]   r_tcnt;
  logic [NUM_CAND-1:0] r_sel;
  logic [9:0]          r_bc;
  logic                r_timeout;
  logic                w_arm;
  logic                w_onehot;
  logic                w_valid;
  logic                w_cast;
  logic                w_expire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only runs while the synced level disagrees with the accepted
  // level, so any glitch back to the accepted level restarts the qualification.
  generate
    for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
      logic [c_DB_W-1:0] r_cnt;
      logic              r_lvl;
      logic              r_evt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
          r_evt <= 1'b0;
        end else begin
          r_evt <= 1'b0;
          if (r_sync2[i] == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DB_LAST) begin
            r_cnt <= '0;
            r_lvl <= r_sync2[i];
            r_evt <= r_sync2[i];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_deb[i]   = r_lvl;
      assign w_press[i] = r_evt;
    end
  endgenerate

  assign w_arm    = voter_en & ~r_ven_q;
  assign w_onehot = (w_press != '0) && ((w_press & (w_press - 1'b1)) == '0);
  // A second button already held down invalidates an otherwise clean press.
  assign w_valid  = w_onehot && ((w_deb & ~w_press) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cast      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_valid) begin
          w_state_nxt = S_CAST;
          w_cast      = 1'b1;
        end else if (r_tcnt == c_TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_expire    = 1'b1;
        end
      end
      S_CAST: begin
        w_state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (w_deb == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ven_q   <= 1'b0;
      r_tcnt    <= '0;
      r_sel     <= '0;
      r_bc      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ven_q   <= voter_en;
      r_timeout <= w_expire;
      if (r_state != S_ARMED) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_cast) begin
        r_sel <= w_press;
        r_bc  <= (r_bc == c_BC_MAX) ? 10'd0 : r_bc + 10'd1;
      end
    end
  end

  assign ready        = (r_state == S_ARMED);
  assign voted        = (r_state == S_CAST);
  assign vote_inc     = (r_state == S_CAST) ? r_sel : '0;
  assign timeout      = r_timeout;
  assign ballots_cast = r_bc;

endmodule
`default_nettype wire

// File: tb/tb_ballot_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ballot_input_ctrl
// Purpose  : Directed and randomized bench for ballot_input_ctrl.
// Revision : 1.0
// ============================================================================
module tb_ballot_input_ctrl;

  localparam int NC = 4;
  localparam int DB = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          voter_en = 1'b0;
  logic [NC-1:0] btn = '0;
  logic [NC-1:0] vote_inc;
  logic          ready;
  logic          voted;
  logic          timeout;
  logic [9:0]    ballots_cast;

  always #5 clk = ~clk;

  ballot_input_ctrl #(
    .NUM_CAND        (NC),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .voter_en     (voter_en),
    .btn          (btn),
    .vote_inc     (vote_inc),
    .ready        (ready),
    .voted        (voted),
    .timeout      (timeout),
    .ballots_cast (ballots_cast)
  );

  int errors = 0;
  int checks = 0;
  int n_votes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: button history window plus a plain ballot record.
  logic [NC-1:0] q[$];
  logic [NC-1:0] m_deb, m_ev, m_sel;
  logic          m_ven_q;
  bit            m_started = 0;
  bit            m_armed, m_cast, m_wait, m_to;
  int            m_age, m_bc;

  always @(posedge clk) begin : mdl
    bit            arm, stable;
    logic [NC-1:0] nd, ne;
    int            sz;
    if (!reset) begin
      m_started = 1;
      m_deb = '0; m_ev = '0; m_sel = '0; m_ven_q = 1'b0;
      m_armed = 0; m_cast = 0; m_wait = 0; m_to = 0;
      m_age = 0; m_bc = 0;
      q.delete();
      for (int j = 0; j < DB + 2; j++) q.push_back('0);
    end else begin
      arm  = voter_en && !m_ven_q;
      m_to = 0;
      if (m_cast) begin
        m_cast = 0;
        m_wait = 1;
      end else if (m_wait) begin
        if (m_deb == '0) m_wait = 0;
      end else if (m_armed) begin
        if ($countones(m_ev) == 1 && $countones(m_deb) == 1) begin
          m_armed = 0;
          m_cast  = 1;
          m_sel   = m_ev;
          m_bc    = (m_bc + 1) % 1000;
        end else if (m_age == TO - 1) begin
          m_armed = 0;
          m_to    = 1;
        end else begin
          m_age++;
        end
      end else if (arm) begin
        m_armed = 1;
        m_age   = 0;
      end
      // A level is accepted once the last DB synchronised samples all disagree with it.
      sz = q.size();
      nd = m_deb;
      ne = '0;
      for (int i = 0; i < NC; i++) begin
        stable = 1;
        for (int j = 0; j < DB; j++)
          if (q[sz-2-j][i] == m_deb[i]) stable = 0;
        if (stable) begin
          nd[i] = ~m_deb[i];
          ne[i] = ~m_deb[i];
        end
      end
      m_deb   = nd;
      m_ev    = ne;
      m_ven_q = voter_en;
    end
    q.push_back(reset ? btn : '0);
    void'(q.pop_front());
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("vote_inc", {28'd0, vote_inc}, {28'd0, (m_cast ? m_sel : 4'b0000)});
      chk("voted", {31'd0, voted}, {31'd0, m_cast});
      chk("ready", {31'd0, ready}, {31'd0, m_armed});
      chk("timeout", {31'd0, timeout}, {31'd0, m_to});
      chk("ballots_cast", {22'd0, ballots_cast}, m_bc);
      if (voted === 1'b1) n_votes++;
    end
  end

  task automatic arm_ballot();
    voter_en = 1'b1;
    cyc(1);
    voter_en = 1'b0;
  endtask

  task automatic cast_vote(input int b);
    arm_ballot();
    btn = NC'(1 << b);
    cyc(8);
    btn = '0;
    cyc(10);
  endtask

  initial begin
    int guard;
    int idx;
    int v0;

    // 1: reset with all buttons pressed, then presses with no ballot armed
    reset = 1'b0; btn = '1; voter_en = 1'b0;
    cyc(3);
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_vote_inc", {28'd0, vote_inc}, 0);
    chk("rst_bc", {22'd0, ballots_cast}, 0);
    reset = 1'b1; btn = 4'b0100;
    cyc(20);
    chk("idle_votes", n_votes, 0);
    chk("idle_bc", {22'd0, ballots_cast}, 0);
    btn = '0;
    cyc(10);

    // 2: normal vote with exact latency
    arm_ballot();
    btn = 4'b0010;
    cyc(6);
    chk("t2_ready", {31'd0, ready}, 1);
    chk("t2_early", {28'd0, vote_inc}, 0);
    cyc(1);
    chk("t2_vote_inc", {28'd0, vote_inc}, 4'b0010);
    chk("t2_voted", {31'd0, voted}, 1);
    chk("t2_bc", {22'd0, ballots_cast}, 1);
    chk("t2_ready_low", {31'd0, ready}, 0);
    cyc(1);
    chk("t2_pulse_len", {28'd0, vote_inc}, 0);
    btn = '0;
    cyc(10);

    // 3: bounce, then a double press, then a clean single press
    arm_ballot();
    for (int i = 0; i < 2; i++) begin
      btn = 4'b0001; cyc(2);
      btn = 4'b0000; cyc(2);
    end
    btn = 4'b1001;
    cyc(7);
    chk("t3_ready", {31'd0, ready}, 1);
    chk("t3_no_vote", n_votes, 1);
    btn = '0;
    cyc(30);
    arm_ballot();
    btn = 4'b0001;
    cyc(7);
    chk("t3_vote_inc", {28'd0, vote_inc}, 4'b0001);
    cyc(1);
    chk("t3_bc", {22'd0, ballots_cast}, 2);
    btn = '0;
    cyc(10);

    // 4: timeout exactly TO cycles after arming
    arm_ballot();
    cyc(TO - 1);
    chk("t4_timeout_early", {31'd0, timeout}, 0);
    chk("t4_ready_armed", {31'd0, ready}, 1);
    cyc(1);
    chk("t4_timeout", {31'd0, timeout}, 1);
    chk("t4_ready", {31'd0, ready}, 0);
    chk("t4_bc", {22'd0, ballots_cast}, 2);
    btn = 4'b0100;
    cyc(10);
    chk("t4_no_vote", n_votes, 2);
    btn = '0;
    cyc(10);

    // 5: a held button cannot vote for the next voter
    arm_ballot();
    btn = 4'b1000;
    cyc(10);
    arm_ballot();
    cyc(10);
    chk("t5_one_vote", n_votes, 3);
    chk("t5_ready", {31'd0, ready}, 0);
    btn = '0;
    cyc(10);
    arm_ballot();
    btn = 4'b1000;
    cyc(10);
    chk("t5_votes", n_votes, 4);
    chk("t5_bc", {22'd0, ballots_cast}, 4);
    btn = '0;
    cyc(10);

    // randomized traffic, including rare resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, NC - 1);
        btn[idx] = ~btn[idx];
      end
      if ($urandom_range(0, 24) == 0) voter_en = ~voter_en;
      reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cyc(1);
    end
    reset = 1'b1; btn = '0; voter_en = 1'b0;
    cyc(40);

    // 6: wrap at 999 and a reset in the middle of a ballot
    guard = 0;
    while (m_bc != 999 && guard < 1100) begin
      cast_vote(guard % NC);
      guard++;
    end
    if (m_bc != 999) chk("t6_preload", m_bc, 999);
    cast_vote(1);
    chk("t6_wrap", {22'd0, ballots_cast}, 0);
    v0 = n_votes;
    arm_ballot();
    btn = 4'b0100;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_vote_inc", {28'd0, vote_inc}, 0);
    chk("t6_rst_ready", {31'd0, ready}, 0);
    chk("t6_rst_voted", {31'd0, voted}, 0);
    chk("t6_rst_timeout", {31'd0, timeout}, 0);
    chk("t6_rst_bc", {22'd0, ballots_cast}, 0);
    reset = 1'b1;
    cyc(15);
    chk("t6_no_vote", n_votes, v0);
    btn = '0;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
